// File: rtl/fir_pkg.sv
// Shared constants, state encoding and sizing helper for the myfir coefficient controller.
package fir_pkg;

    localparam int NB     = 14;
    localparam int N_TAPS = 9;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_SWAP_WAIT = 2'd2;
    localparam logic [1:0] ST_FLUSH     = 2'd3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fir_coef_ctrl_if.sv
// Bundle of the config stream, upstream sample stream, FIR-facing and sink-facing signals.
interface fir_coef_ctrl_if #(
    parameter int NB     = fir_pkg::NB,
    parameter int N_TAPS = fir_pkg::N_TAPS
) ();

    logic                   CFG_VALID;
    logic [NB-1:0]          CFG_DATA;
    logic                   CFG_LAST;
    logic                   CFG_READY;
    logic                   VIN_S;
    logic [NB-1:0]          DIN_S;
    logic                   READY_S;
    logic                   VIN;
    logic [NB-1:0]          DIN;
    logic [N_TAPS*NB-1:0]   B_FLAT;
    logic                   VOUT_F;
    logic [NB-1:0]          DOUT_F;
    logic                   VOUT;
    logic [NB-1:0]          DOUT;
    logic                   CFG_ERR;
    logic                   SWAP_DONE;

    modport master (
        output CFG_VALID, CFG_DATA, CFG_LAST, VIN_S, DIN_S, VOUT_F, DOUT_F,
        input  CFG_READY, READY_S, VIN, DIN, B_FLAT, VOUT, DOUT, CFG_ERR, SWAP_DONE
    );

    modport slave (
        input  CFG_VALID, CFG_DATA, CFG_LAST, VIN_S, DIN_S, VOUT_F, DOUT_F,
        output CFG_READY, READY_S, VIN, DIN, B_FLAT, VOUT, DOUT, CFG_ERR, SWAP_DONE
    );

endinterface

// File: rtl/fir_coef_bank.sv
// Shadow and active coefficient registers; shadow is written word by word, active
// takes the whole shadow in one edge so the FIR never sees a partial set.
module fir_coef_bank #(
    parameter int N_TAPS = fir_pkg::N_TAPS,
    parameter int NB     = fir_pkg::NB,
    parameter int IDX_W  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [IDX_W-1:0]       wr_idx_i,
    input  logic signed [NB-1:0]   wr_data_i,
    input  logic                   swap_i,
    output logic [N_TAPS*NB-1:0]   b_flat_o
);

    logic signed [NB-1:0] shadow_q [N_TAPS];
    logic signed [NB-1:0] active_q [N_TAPS];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_TAPS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                shadow_q[wr_idx_i] <= wr_data_i;
            end
            if (swap_i) begin
                active_q <= shadow_q;
            end
        end
    end

    always_comb begin
        b_flat_o = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            b_flat_o[i*NB +: NB] = active_q[i];
        end
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Run-time coefficient configurator for myfir: loads a shadow set from a serial stream,
// swaps it in on a sample-free edge and masks FIR outputs produced across the swap.
module fir_coef_ctrl #(
    parameter int N_TAPS   = fir_pkg::N_TAPS,
    parameter int NB       = fir_pkg::NB,
    parameter int FIR_LAT  = 2,
    parameter int MAX_WAIT = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    fir_coef_ctrl_if.slave   bus
);

    import fir_pkg::*;

    localparam int IDX_W  = (clog2(N_TAPS) < 1)     ? 1 : clog2(N_TAPS);
    localparam int WAIT_W = (clog2(MAX_WAIT+1) < 1) ? 1 : clog2(MAX_WAIT+1);
    localparam int MASK_W = (clog2(FIR_LAT+1) < 1)  ? 1 : clog2(FIR_LAT+1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic cfg_ready, force_swap, accept, do_swap, last_word;

    always_comb begin
        cfg_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
        force_swap = (state_q == ST_SWAP_WAIT) && (wait_q == WAIT_W'(MAX_WAIT));
        accept     = bus.CFG_VALID && cfg_ready;
        // A forced swap blocks the upstream, so the swap edge never carries a sample.
        do_swap    = (state_q == ST_SWAP_WAIT) && (!bus.VIN_S || force_swap);
        last_word  = (idx_q == IDX_W'(N_TAPS - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        mask_d  = mask_q;
        err_d   = err_q;
        done_d  = do_swap;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                // idx_q is always 0 in IDLE, so both states share the framing rules.
                if (accept) begin
                    err_d = 1'b0;
                    if (bus.CFG_LAST && last_word) begin
                        state_d = ST_SWAP_WAIT;
                        idx_d   = '0;
                        wait_d  = '0;
                    end else if (bus.CFG_LAST || last_word) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_LOAD;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            ST_SWAP_WAIT: begin
                if (do_swap) begin
                    mask_d  = MASK_W'(FIR_LAT);
                    state_d = (FIR_LAT == 0) ? ST_IDLE : ST_FLUSH;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                if (bus.VOUT_F) begin
                    mask_d = mask_q - 1'b1;
                    if (mask_q == MASK_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    fir_coef_bank #(
        .N_TAPS (N_TAPS),
        .NB     (NB),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk_i     (CLK),
        .rst_ni    (RST_n),
        .wr_en_i   (accept),
        .wr_idx_i  (idx_q),
        .wr_data_i (bus.CFG_DATA),
        .swap_i    (do_swap),
        .b_flat_o  (bus.B_FLAT)
    );

    assign bus.CFG_READY = cfg_ready;
    assign bus.READY_S   = !force_swap;
    assign bus.VIN       = bus.VIN_S && !force_swap;
    assign bus.DIN       = bus.DIN_S;
    assign bus.VOUT      = bus.VOUT_F && (mask_q == '0);
    assign bus.DOUT      = bus.DOUT_F;
    assign bus.CFG_ERR   = err_q;
    assign bus.SWAP_DONE = done_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl with a transaction-level reference model and per-cycle compare.
module tb_fir_coef_ctrl;

    localparam int NB       = 14;
    localparam int N_TAPS   = 9;
    localparam int FIR_LAT  = 2;
    localparam int MAX_WAIT = 16;

    localparam logic [N_TAPS*NB-1:0] LIT_A = {14'd9, 14'd8, 14'd7, 14'd6, 14'd5,
                                              14'd4, 14'd3, 14'd2, 14'd1};
    localparam logic [N_TAPS*NB-1:0] LIT_B = {14'd109, 14'd108, 14'd107, 14'd106, 14'd105,
                                              14'd104, 14'd103, 14'd102, 14'd101};
    localparam logic [N_TAPS*NB-1:0] LIT_C = {14'h3FFF, 14'h3FFE, 14'h3FFD, 14'h3FFC, 14'h3FFB,
                                              14'h3FFA, 14'h3FF9, 14'h3FF8, 14'h3FF7};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_coef_ctrl_if #(.NB(NB), .N_TAPS(N_TAPS)) bus ();

    fir_coef_ctrl #(
        .N_TAPS   (N_TAPS),
        .NB       (NB),
        .FIR_LAT  (FIR_LAT),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .CLK   (clk),
        .RST_n (rst_n),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collected words, a pending complete set, cycles waited, pulses left to hide.
    logic signed [NB-1:0] m_active [N_TAPS];
    logic signed [NB-1:0] m_pend   [N_TAPS];
    logic signed [NB-1:0] m_words  [$];
    bit m_pending, m_err, m_done;
    int m_wait, m_flush;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int i = 0; i < N_TAPS; i++) begin
                    m_active[i] = '0;
                    m_pend[i]   = '0;
                end
                m_words.delete();
                m_pending = 0; m_err = 0; m_done = 0; m_wait = 0; m_flush = 0;
            end else begin
                m_done = 0;
                if (m_pending) begin
                    if (!bus.VIN_S || m_wait == MAX_WAIT) begin
                        m_active  = m_pend;
                        m_pending = 0;
                        m_flush   = FIR_LAT;
                        m_done    = 1;
                    end else begin
                        m_wait++;
                    end
                end else if (m_flush > 0) begin
                    if (bus.VOUT_F) m_flush--;
                end else if (bus.CFG_VALID) begin
                    m_err = 0;
                    m_words.push_back(bus.CFG_DATA);
                    if (bus.CFG_LAST || m_words.size() == N_TAPS) begin
                        if (bus.CFG_LAST && m_words.size() == N_TAPS) begin
                            for (int i = 0; i < N_TAPS; i++) m_pend[i] = m_words[i];
                            m_pending = 1;
                            m_wait    = 0;
                        end else begin
                            m_err = 1;
                        end
                        m_words.delete();
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic [N_TAPS*NB-1:0] exp_b;
                bit exp_rs;
                exp_b = '0;
                for (int i = 0; i < N_TAPS; i++) exp_b[i*NB +: NB] = m_active[i];
                exp_rs = !(m_pending && m_wait == MAX_WAIT);
                check("cyc_B_FLAT",    bus.B_FLAT,    exp_b);
                check("cyc_CFG_READY", bus.CFG_READY, !m_pending && m_flush == 0);
                check("cyc_READY_S",   bus.READY_S,   exp_rs);
                check("cyc_VIN",       bus.VIN,       bus.VIN_S && exp_rs);
                check("cyc_DIN",       bus.DIN,       bus.DIN_S);
                check("cyc_VOUT",      bus.VOUT,      bus.VOUT_F && m_flush == 0);
                check("cyc_DOUT",      bus.DOUT,      bus.DOUT_F);
                check("cyc_CFG_ERR",   bus.CFG_ERR,   m_err);
                check("cyc_SWAP_DONE", bus.SWAP_DONE, m_done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input int n, input int base, input int last_at);
        for (int i = 0; i < n; i++) begin
            bus.CFG_VALID = 1'b1;
            bus.CFG_DATA  = NB'(base + i);
            bus.CFG_LAST  = (i + 1 == last_at);
            tick();
        end
        bus.CFG_VALID = 1'b0;
        bus.CFG_LAST  = 1'b0;
    endtask

    task automatic fir_pulse(input logic [NB-1:0] d, input logic exp_vout, input string nm);
        bus.VOUT_F = 1'b1;
        bus.DOUT_F = d;
        #1;
        check(nm, bus.VOUT, exp_vout);
        tick();
        bus.VOUT_F = 1'b0;
    endtask

    initial begin
        int low_at, low_cnt;
        bit rs;
        bus.CFG_VALID = 0; bus.CFG_DATA = '0; bus.CFG_LAST = 0;
        bus.VIN_S = 0; bus.DIN_S = '0; bus.VOUT_F = 0; bus.DOUT_F = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_B_FLAT",    bus.B_FLAT,    '0);
        check("rst_CFG_READY", bus.CFG_READY, 1'b1);
        check("rst_READY_S",   bus.READY_S,   1'b1);
        check("rst_CFG_ERR",   bus.CFG_ERR,   1'b0);
        check("rst_SWAP_DONE", bus.SWAP_DONE, 1'b0);

        // Normal load with an idle upstream: swap on the very next edge.
        send_words(9, 1, 9);
        check("load_B_before",    bus.B_FLAT,    '0);
        check("load_done_before", bus.SWAP_DONE, 1'b0);
        check("load_ready_wait",  bus.CFG_READY, 1'b0);
        tick();
        check("load_B_FLAT",      bus.B_FLAT,    LIT_A);
        check("load_SWAP_DONE",   bus.SWAP_DONE, 1'b1);
        tick();
        check("load_done_once",   bus.SWAP_DONE, 1'b0);

        fir_pulse(14'd100, 1'b0, "flush_p1");
        fir_pulse(14'd200, 1'b0, "flush_p2");
        fir_pulse(14'd300, 1'b1, "flush_p3");
        check("flush_idle_ready", bus.CFG_READY, 1'b1);

        send_words(5, 21, 5);
        check("early_CFG_ERR", bus.CFG_ERR,   1'b1);
        check("early_B_FLAT",  bus.B_FLAT,    LIT_A);
        check("early_READY",   bus.CFG_READY, 1'b1);

        send_words(9, 31, 0);
        check("miss_CFG_ERR", bus.CFG_ERR, 1'b1);
        check("miss_B_FLAT",  bus.B_FLAT,  LIT_A);

        // Forced swap: upstream always has a sample, so the idle slot must be forced.
        bus.VIN_S = 1'b1;
        bus.DIN_S = 14'd500;
        send_words(9, 101, 9);
        check("force_err_clr", bus.CFG_ERR, 1'b0);
        low_at = -1;
        low_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            rs = bus.READY_S;
            if (!rs) begin
                low_cnt++;
                if (low_at < 0) low_at = c;
                check("force_VIN_blocked", bus.VIN, 1'b0);
            end
            tick();
            if (rs) bus.DIN_S = bus.DIN_S + 1'b1;
        end
        check("force_low_at",  low_at,  16);
        check("force_low_cnt", low_cnt, 1);
        check("force_B_FLAT",  bus.B_FLAT, LIT_B);
        bus.VIN_S = 1'b0;
        fir_pulse(14'd7, 1'b0, "force_flush_p1");
        fir_pulse(14'd8, 1'b0, "force_flush_p2");
        check("force_idle", bus.CFG_READY, 1'b1);

        send_words(4, 1, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_B_FLAT", bus.B_FLAT,    '0);
        check("midrst_READY",  bus.CFG_READY, 1'b1);
        send_words(9, -9, 9);
        tick();
        check("reload_B_FLAT", bus.B_FLAT, LIT_C);
        fir_pulse(14'h3FFF, 1'b0, "reload_flush_p1");
        fir_pulse(14'h1234, 1'b0, "reload_flush_p2");
        fir_pulse(14'h0042, 1'b1, "reload_pass");

        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
